data_mem_bridge: RTL and testbench

//  Sits between the CPU MEM stage and the word-wide data RAM (ram_0: clk, we, a, d, async spo).

---
 rtl/dmb_pkg.sv | 39 +++
 rtl/data_mem_bridge_lane.sv | 40 ++++
 rtl/data_mem_bridge.sv | 131 +++++++++++++
 tb/tb_data_mem_bridge.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmb_pkg.sv
// rtl/dmb_pkg.sv - shared types and op helpers for the data memory bridge
package dmb_pkg;

  typedef enum logic [2:0] {
    LD_B  = 3'd0,
    LD_H  = 3'd1,
    LD_W  = 3'd2,
    LD_BU = 3'd3,
    LD_HU = 3'd4,
    ST_B  = 3'd5,
    ST_H  = 3'd6,
    ST_W  = 3'd7
  } mem_op_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WRITE  = 2'd2,
    RESP   = 2'd3
  } dmb_state_e;

  function automatic logic is_load(mem_op_e op);
    return (op == LD_B) || (op == LD_H) || (op == LD_W) ||
           (op == LD_BU) || (op == LD_HU);
  endfunction

  function automatic logic is_subword_store(mem_op_e op);
    return (op == ST_B) || (op == ST_H);
  endfunction

  function automatic logic is_misaligned(mem_op_e op, logic [1:0] off);
    logic half_op;
    logic word_op;
    half_op = (op == LD_H) || (op == LD_HU) || (op == ST_H);
    word_op = (op == LD_W) || (op == ST_W);
    return (half_op && off[0]) || (word_op && (off != 2'b00));
  endfunction

endpackage

// File: rtl/data_mem_bridge_lane.sv
// rtl/data_mem_bridge_lane.sv - dmb_lane_unit: load lane extract/extend and store lane merge
module dmb_lane_unit
  import dmb_pkg::*;
(
  input  mem_op_e     op,
  input  logic [1:0]  off,
  input  logic [31:0] word,
  input  logic [15:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  logic [31:0] shifted;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    shifted   = word >> {off, 3'b000};
    byte_v    = shifted[7:0];
    half_v    = off[1] ? word[31:16] : word[15:0];
    load_data = 32'h0;
    case (op)
      LD_B:    load_data = {{24{byte_v[7]}}, byte_v};
      LD_BU:   load_data = {24'h0, byte_v};
      LD_H:    load_data = {{16{half_v[15]}}, half_v};
      LD_HU:   load_data = {16'h0, half_v};
      LD_W:    load_data = word;
      default: load_data = 32'h0;
    endcase

    merged = word;
    if (op == ST_B) begin
      merged[{off, 3'b000} +: 8] = wdata[7:0];
    end else if (op == ST_H) begin
      if (off[1]) merged[31:16] = wdata;
      else        merged[15:0]  = wdata;
    end
  end

endmodule

// File: rtl/data_mem_bridge.sv
// rtl/data_mem_bridge.sv - CPU MEM stage to word-wide data RAM bridge with sub-word RMW
// Optional alignment checking with resp_err when DMB_ALIGN_CHECK_EN is defined.
module data_mem_bridge
  import dmb_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_a,
  output logic [31:0]       ram_d,
  input  logic [31:0]       ram_spo
);

  dmb_state_e        state_q, state_d;
  mem_op_e           op_q, op_d;
  logic [ADDR_W+1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [31:0]       merge_q, merge_d;
  logic              err_q, err_d;

  logic [31:0] lane_word;
  logic [31:0] load_data;
  logic [31:0] merged;
  logic        misalign;
  logic        unused_addr_hi;

  assign unused_addr_hi = ^req_addr[31:ADDR_W+2];

`ifdef DMB_ALIGN_CHECK_EN
  assign misalign = is_misaligned(op_q, addr_q[1:0]);
`else
  assign misalign = 1'b0;
`endif

  // WRITE merges into the word captured during ACCESS, not the live RAM output.
  assign lane_word = (state_q == WRITE) ? merge_q : ram_spo;

  dmb_lane_unit u_lane (
    .op        (op_q),
    .off       (addr_q[1:0]),
    .word      (lane_word),
    .wdata     (wdata_q[15:0]),
    .load_data (load_data),
    .merged    (merged)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    merge_d = merge_q;
    err_d   = err_q;
    ram_we  = 1'b0;
    ram_d   = 32'h0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          op_d    = mem_op_e'(req_op);
          addr_d  = req_addr[ADDR_W+1:0];
          wdata_d = req_wdata;
          rdata_d = 32'h0;
          err_d   = 1'b0;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        state_d = RESP;
        if (misalign) begin
          err_d = 1'b1;
        end else if (is_load(op_q)) begin
          rdata_d = load_data;
        end else if (op_q == ST_W) begin
          ram_we = 1'b1;
          ram_d  = wdata_q;
        end else if (is_subword_store(op_q)) begin
          merge_d = ram_spo;
          state_d = WRITE;
        end
      end
      WRITE: begin
        ram_we  = 1'b1;
        ram_d   = merged;
        state_d = RESP;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= LD_B;
      addr_q  <= '0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      merge_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      merge_q <= merge_d;
      err_q   <= err_d;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign ram_a      = addr_q[ADDR_W+1:2];

endmodule

// File: tb/tb_data_mem_bridge.sv
// tb/tb_data_mem_bridge.sv - randomized self-checking bench for data_mem_bridge
module tb_data_mem_bridge;
  import dmb_pkg::*;

  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [2:0]    req_op = 3'd0;
  logic [31:0]   req_addr = 32'h0;
  logic [31:0]   req_wdata = 32'h0;
  logic          resp_valid;
  logic [31:0]   resp_rdata;
  logic          resp_err;
  logic          ram_we;
  logic [AW-1:0] ram_a;
  logic [31:0]   ram_d;
  logic [31:0]   ram_spo;

  data_mem_bridge #(.ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .ram_we(ram_we), .ram_a(ram_a), .ram_d(ram_d), .ram_spo(ram_spo)
  );

  always #5 clk = ~clk;

  logic [31:0] ram [0:(1<<AW)-1];
  assign ram_spo = ram[ram_a];
  always @(posedge clk) if (ram_we) ram[ram_a] <= ram_d;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] ref_mem [0:(1<<AW)-1];
  int tests = 0;
  int fails = 0;

  typedef struct { logic [31:0] rdata; logic err; int due; } resp_t;
  typedef struct { logic [AW-1:0] a; logic [31:0] d; } wr_t;
  resp_t rq[$];
  wr_t   wq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic mis(input int op, input logic [31:0] addr);
`ifdef DMB_ALIGN_CHECK_EN
    return ((op == LD_H || op == LD_HU || op == ST_H) && addr[0]) ||
           ((op == LD_W || op == ST_W) && (addr[1:0] != 2'b00));
`else
    return 1'b0;
`endif
  endfunction

  task automatic model(input int op, input logic [31:0] addr, input logic [31:0] wd,
                       output logic [31:0] rd, output logic err, output int lat);
    logic [AW-1:0] w;
    logic [31:0] old, b, h;
    int bsh, hsh;
    w   = addr[AW+1:2];
    old = ref_mem[w];
    bsh = 8 * int'(addr[1:0]);
    hsh = 16 * int'(addr[1]);
    b   = (old >> bsh) & 32'hFF;
    h   = (old >> hsh) & 32'hFFFF;
    rd  = 32'h0;
    err = 1'b0;
    lat = 2;
    if (mis(op, addr)) begin
      err = 1'b1;
      return;
    end
    case (op)
      0: rd = b[7] ? (b | 32'hFFFFFF00) : b;
      1: rd = h[15] ? (h | 32'hFFFF0000) : h;
      2: rd = old;
      3: rd = b;
      4: rd = h;
      5: begin
        ref_mem[w] = (old & ~(32'hFF << bsh)) | ((wd & 32'hFF) << bsh);
        lat = 3;
        wq.push_back('{w, ref_mem[w]});
      end
      6: begin
        ref_mem[w] = (old & ~(32'hFFFF << hsh)) | ((wd & 32'hFFFF) << hsh);
        lat = 3;
        wq.push_back('{w, ref_mem[w]});
      end
      default: begin
        ref_mem[w] = wd;
        wq.push_back('{w, wd});
      end
    endcase
  endtask

  task automatic issue(input int op, input logic [31:0] addr, input logic [31:0] wd,
                       input bit hold, input bit noise, output logic [31:0] exp_rd);
    int n;
    logic e;
    int lat;
    n = 0;
    exp_rd = 32'h0;
    @(negedge clk);
    while (!req_ready) begin
      if (noise) begin
        req_valid = 1'($urandom_range(1));
        req_op    = 3'($urandom_range(7));
        req_addr  = $urandom;
        req_wdata = $urandom;
      end
      n++;
      if (n > 50) begin
        tests++;
        fails++;
        $display("FAIL issue_timeout: req_ready stayed 0 for %0d cycles, required 1", n);
        return;
      end
      @(negedge clk);
    end
    req_valid = 1'b1;
    req_op    = 3'(op);
    req_addr  = addr;
    req_wdata = wd;
    @(posedge clk);
    #1;
    model(op, addr, wd, exp_rd, e, lat);
    rq.push_back('{exp_rd, e, cyc - 1 + lat});
    if (hold) begin
      req_op    = 3'($urandom_range(7));
      req_addr  = $urandom;
      req_wdata = $urandom;
    end else begin
      req_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((rq.size() != 0 || wq.size() != 0) && n < 20) begin
      @(negedge clk);
      n++;
    end
    req_valid = 1'b0;
    tests++;
    if (rq.size() != 0 || wq.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d responses and %0d writes outstanding, required 0", rq.size(), wq.size());
      rq.delete();
      wq.delete();
    end
    @(negedge clk);
  endtask

  // Cycle-by-cycle comparison of DUT outputs against the expectation queues.
  always @(negedge clk) begin
    if (!rst) begin
      chk("req_ready", 32'(req_ready), 32'(rq.size() == 0));
      if (resp_valid) begin
        if (rq.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL spurious_resp: resp_valid=1 with nothing outstanding, required 0");
        end else begin
          resp_t r;
          r = rq.pop_front();
          chk("resp_rdata", resp_rdata, r.rdata);
          chk("resp_err", 32'(resp_err), 32'(r.err));
          chk("resp_latency", 32'(cyc), 32'(r.due));
        end
      end else if (rq.size() != 0 && cyc > rq[0].due) begin
        tests++;
        fails++;
        $display("FAIL resp_timeout: no resp_valid at cycle %0d, required by %0d", cyc, rq[0].due);
        void'(rq.pop_front());
      end
      if (ram_we) begin
        if (wq.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL spurious_we: ram_we=1 a=0x%03h d=0x%08h, required no write", ram_a, ram_d);
        end else begin
          wr_t w;
          w = wq.pop_front();
          chk("ram_a", 32'(ram_a), 32'(w.a));
          chk("ram_d", ram_d, w.d);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, old5;
    int n;
    for (int i = 0; i < (1 << AW); i++) ref_mem[i] = 32'h0;

    repeat (3) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    chk("rst_ram_we", 32'(ram_we), 32'd0);
    chk("rst_ram_a", 32'(ram_a), 32'd0);
    chk("rst_ram_d", ram_d, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 16; i++) issue(ST_W, 32'(i * 4), $urandom, 1'b0, 1'b0, rd);
    drain();

    issue(ST_W, 32'h10, 32'h8899AABB, 1'b0, 1'b0, rd);
    issue(LD_B, 32'h12, 32'h0, 1'b0, 1'b0, rd);
    chk("t1_ld_b", rd, 32'hFFFFFF99);
    issue(LD_BU, 32'h12, 32'h0, 1'b0, 1'b0, rd);
    chk("t1_ld_bu", rd, 32'h00000099);
    issue(ST_B, 32'h11, 32'h000000CC, 1'b0, 1'b0, rd);
    drain();
    chk("t2_merge", ref_mem[4], 32'h8899CCBB);

    issue(ST_W, 32'h20, 32'hFFFFFFFF, 1'b0, 1'b0, rd);
    issue(ST_H, 32'h22, 32'h00001234, 1'b0, 1'b0, rd);
    issue(LD_H, 32'h22, 32'h0, 1'b0, 1'b0, rd);
    chk("t3_ld_h_hi", rd, 32'h00001234);
    issue(LD_H, 32'h20, 32'h0, 1'b0, 1'b0, rd);
    chk("t3_ld_h_lo", rd, 32'hFFFFFFFF);

    issue(ST_W, 32'h0, 32'hDEADBEEF, 1'b1, 1'b0, rd);
    issue(LD_W, 32'h0, 32'h0, 1'b1, 1'b0, rd);
    chk("t4_ld_w", rd, 32'hDEADBEEF);
    drain();

    issue(ST_W, 32'h2, 32'h55667788, 1'b0, 1'b0, rd);
    drain();
`ifdef DMB_ALIGN_CHECK_EN
    chk("t5_word0", ref_mem[0], 32'hDEADBEEF);
`else
    chk("t5_word0", ref_mem[0], 32'h55667788);
`endif

    old5 = ref_mem[5];
    issue(ST_B, 32'h15, 32'h000000AA, 1'b0, 1'b0, rd);
    n = 0;
    while (!ram_we && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("t6_reached_write", 32'(ram_we), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    chk("t6_we_drop", 32'(ram_we), 32'd0);
    chk("t6_resp_valid", 32'(resp_valid), 32'd0);
    rq.delete();
    wq.delete();
    ref_mem[5] = old5;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("t6_ready", 32'(req_ready), 32'd1);
    chk("t6_ram_unchanged", ram[5], old5);
    issue(LD_W, 32'h14, 32'h0, 1'b0, 1'b0, rd);
    chk("t6_ld_w_model", rd, old5);
    drain();

    for (int i = 0; i < 300; i++) begin
      logic [31:0] a;
      a = ($urandom & 32'hFFFFF000) | (32'($urandom_range(15)) << 2) | 32'($urandom_range(3));
      issue(int'($urandom_range(7)), a, $urandom, 1'($urandom_range(1)), 1'b1, rd);
    end
    drain();

    for (int i = 0; i < 16; i++) chk($sformatf("final_ram_%0d", i), ram[i], ref_mem[i]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
